// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: state encoding and frame length.
// The frame-length helper honours FIFO_UART_PARITY_EN.
package fifo_uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_WAIT   = WAIT,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP
  } state_t;

  // Cycles from the start-bit edge to the end of the stop bit.
  function automatic int frame_cycles(input int dw, input int cpb);
`ifdef FIFO_UART_PARITY_EN
    return (dw + 3) * cpb;
`else
    return (dw + 2) * cpb;
`endif
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: tick on the last cycle of each bit, pre_tick one cycle earlier.
// clear holds the counter at zero so a frame always starts on a fresh bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear)   cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = !clear && (cnt == LAST);

  // With one-cycle bits there is no "cycle before the last one".
  generate
    if (CLKS_PER_BIT > 1) begin : g_pre
      assign pre_tick = !clear && (cnt == CNT_W'(CLKS_PER_BIT - 2));
    end else begin : g_no_pre
      assign pre_tick = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a synchronous FIFO one word at a time: start, data LSB-first,
// optional even parity (FIFO_UART_PARITY_EN), stop. Each bit lasts CLKS_PER_BIT cycles.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_val,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic ONE_CLK_BIT = (CLKS_PER_BIT == 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [BIT_W-1:0]      bit_idx;
  logic                  tick, pre_tick, baud_clr;
`ifdef FIFO_UART_PARITY_EN
  logic                  par;
`endif

  assign shift_nxt = shift >> 1;
  assign baud_clr  = (state == S_IDLE) || (state == S_WAIT);
  // Only IDLE may request, so at most one word is ever in flight.
  assign rd_en     = !reset && (state == S_IDLE) && rd_val;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clr),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // tx/busy/tx_done are registered, so each is loaded with its value for the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
`ifdef FIFO_UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: if (rd_val) begin
          state <= S_WAIT;
          busy  <= 1'b1;
        end
        S_WAIT: begin
          shift   <= rd_data;
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= S_START;
`ifdef FIFO_UART_PARITY_EN
          par     <= ^rd_data;
`endif
        end
        S_START: if (tick) begin
          tx    <= shift[0];
          state <= S_DATA;
        end
        S_DATA: if (tick) begin
          if (bit_idx == LAST_BIT) begin
`ifdef FIFO_UART_PARITY_EN
            tx      <= par;
            state   <= S_PARITY;
`else
            tx      <= 1'b1;
            tx_done <= ONE_CLK_BIT;
            state   <= S_STOP;
`endif
          end else begin
            shift   <= shift_nxt;
            tx      <= shift_nxt[0];
            bit_idx <= bit_idx + 1'b1;
          end
        end
`ifdef FIFO_UART_PARITY_EN
        S_PARITY: if (tick) begin
          tx      <= 1'b1;
          tx_done <= ONE_CLK_BIT;
          state   <= S_STOP;
        end
`endif
        S_STOP: begin
          if (pre_tick) tx_done <= 1'b1;
          if (tick) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench: a queue-backed FIFO model feeds the DUT, a line monitor decodes frames
// cycle by cycle and checks them against words queued when the stimulus was issued.
module tb_fifo_uart_tx;

  localparam int DW = 4;
  localparam int C  = 4;
`ifdef FIFO_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = DW + 2 + PAR;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd_val = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic rd_en, tx, busy, tx_done;
  logic rd_val1 = 1'b0;
  logic [DW-1:0] rd_data1 = '0;
  logic rd_en1, tx1, busy1, tx_done1;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rden_cnt = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int rden_cyc[$];
  int start_cyc[$];

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rd_val(rd_val), .rd_data(rd_data),
    .rd_en(rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .rd_val(rd_val1), .rd_data(rd_data1),
    .rd_en(rd_en1), .tx(tx1), .busy(busy1), .tx_done(tx_done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // FIFO model: rd_val follows occupancy; a handshake seen mid-cycle pops the word, which
  // then stays on rd_data through the DUT's WAIT cycle.
  initial forever begin
    @(negedge clk);
    rd_val = (fifo_q.size() != 0);
    #1;
    if (rd_en === 1'b1 && rd_val) begin
      rd_data = fifo_q.pop_front();
      rden_cnt++;
      rden_cyc.push_back(cyc);
    end
  end

  // Line monitor: on a falling edge, sample every cycle of a full frame.
  initial begin : mon
    logic prev;
    logic [NB-1:0] line, exp_line;
    logic [DW-1:0] w;
    logic exp_done;
    bit stable, done_ok, abort;
    int sc;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && prev === 1'b1 && tx === 1'b0) begin
        sc = cyc; stable = 1; done_ok = 1; abort = 0; line = '0;
        for (int b = 0; b < NB; b++) begin
          for (int j = 0; j < C; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (!mon_en || reset) abort = 1;
            if (j == 0) line[b] = tx;
            else if (tx !== line[b]) stable = 0;
            exp_done = (b == NB - 1) && (j == C - 1);
            if (tx_done !== exp_done) done_ok = 0;
          end
        end
        prev = tx;
        if (!abort) begin
          start_cyc.push_back(sc);
          n_chk++;
          if (exp_q.size() == 0) begin
            $display("FAIL frame_unexpected: got frame %b, expected no frame", line);
          end else begin
            w = exp_q.pop_front();
`ifdef FIFO_UART_PARITY_EN
            exp_line = {1'b1, ^w, w, 1'b0};
`else
            exp_line = {1'b1, w, 1'b0};
`endif
            if (line !== exp_line || !stable)
              $display("FAIL frame_bits: got %b (stable=%0d), required %b for word %h",
                       line, stable, exp_line, w);
            else n_pass++;
            n_chk++;
            if (!done_ok) $display("FAIL frame_tx_done: pulse off, required only in last stop cycle, word %h", w);
            else n_pass++;
          end
        end
      end else begin
        prev = tx;
      end
    end
  end

  task automatic wait_idle(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_q.size() == 0 && busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok = 1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk); #2;
      if (tx !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) ok = 0;
    end
    n_chk++;
    if (!ok) $display("FAIL reset_hold: tx=%b rd_en=%b busy=%b tx_done=%b, required 1 0 0 0",
                      tx, rd_en, busy, tx_done);
    else n_pass++;
    reset = 1'b0;
    ok = 1;
    repeat (3) begin
      @(negedge clk); #2;
      if (tx !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) ok = 0;
    end
    n_chk++;
    if (!ok) $display("FAIL reset_release: tx=%b rd_en=%b busy=%b, required 1 0 0", tx, rd_en, busy);
    else n_pass++;
  endtask

  task automatic test_idle;
    bit ok = 1;
    repeat (20) begin
      @(negedge clk); #2;
      if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) ok = 0;
    end
    n_chk++;
    if (!ok) $display("FAIL idle_empty: tx=%b busy=%b rd_en=%b, required 1 0 0", tx, busy, rd_en);
    else n_pass++;
  endtask

  task automatic test_single;
    int c0 = rden_cnt;
    bit ok;
    mon_en = 1'b1;
    fifo_q.push_back(4'd7);
    exp_q.push_back(4'd7);
    wait_idle(200, ok);
    n_chk++;
    if (!ok) $display("FAIL single_timeout: frame not finished, exp_q=%0d", exp_q.size());
    else n_pass++;
    n_chk++;
    if (rden_cnt - c0 != 1) $display("FAIL single_rd_en: got %0d pulses, required 1", rden_cnt - c0);
    else n_pass++;
    n_chk++;
    if (start_cyc[$] - rden_cyc[$] != 2)
      $display("FAIL single_latency: start %0d cycles after rd_en, required 2", start_cyc[$] - rden_cyc[$]);
    else n_pass++;
  endtask

  task automatic test_patterns;
    logic [DW-1:0] pat[4] = '{4'd6, 4'd0, 4'hF, 4'hA};
    bit ok;
    foreach (pat[i]) begin
      fifo_q.push_back(pat[i]);
      exp_q.push_back(pat[i]);
    end
    wait_idle(600, ok);
    n_chk++;
    if (!ok) $display("FAIL patterns_timeout: exp_q=%0d left, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int c0 = rden_cnt;
    int s0 = start_cyc.size();
    bit ok;
    fifo_q.push_back(4'd7); exp_q.push_back(4'd7);
    fifo_q.push_back(4'd6); exp_q.push_back(4'd6);
    fifo_q.push_back(4'd5); exp_q.push_back(4'd5);
    wait_idle(500, ok);
    n_chk++;
    if (!ok || start_cyc.size() - s0 != 3)
      $display("FAIL b2b_frames: got %0d frames (done=%0d), required 3", start_cyc.size() - s0, ok);
    else n_pass++;
    n_chk++;
    if (rden_cnt - c0 != 3) $display("FAIL b2b_rd_en: got %0d pulses, required 3", rden_cnt - c0);
    else n_pass++;
    for (int k = 1; k < 3; k++) begin
      n_chk++;
      if (start_cyc.size() < s0 + 3 || start_cyc[s0+k] - start_cyc[s0+k-1] != NB * C + 2)
        $display("FAIL b2b_spacing: gap %0d got %0d cycles, required %0d", k,
                 (start_cyc.size() >= s0 + 3) ? start_cyc[s0+k] - start_cyc[s0+k-1] : -1, NB * C + 2);
      else n_pass++;
    end
    n_chk++;
    if (fifo_q.size() != 0 || rd_val !== 1'b0)
      $display("FAIL b2b_fifo_empty: got %0d words rd_val=%b, required 0 0", fifo_q.size(), rd_val);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    bit ok;
    mon_en = 1'b0;
    fifo_q.push_back(4'd3);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin found = 1; break; end
    end
    n_chk++;
    if (!found) $display("FAIL rmid_start: no start bit seen, required one within 50 cycles");
    else n_pass++;
    repeat (3 * C + 1) @(negedge clk);
    n_chk++;
    if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL rmid_in_bit2: tx=%b busy=%b, required 0 1", tx, busy);
    else n_pass++;
    reset = 1'b1;
    fifo_q.push_back(4'd9);
    exp_q.push_back(4'd9);
    @(negedge clk); #2;
    n_chk++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || rd_en !== 1'b0)
      $display("FAIL rmid_reset: tx=%b busy=%b tx_done=%b rd_en=%b, required 1 0 0 0", tx, busy, tx_done, rd_en);
    else n_pass++;
    @(negedge clk); #2;
    n_chk++;
    if (rd_en !== 1'b0 || rd_val !== 1'b1)
      $display("FAIL rmid_no_rd_en: rd_en=%b rd_val=%b under reset, required 0 1", rd_en, rd_val);
    else n_pass++;
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    n_chk++;
    if (rd_en !== 1'b1) $display("FAIL rmid_first_rd_en: rd_en=%b after release, required 1", rd_en);
    else n_pass++;
    wait_idle(200, ok);
    n_chk++;
    if (!ok || start_cyc[$] - rden_cyc[$] != 2)
      $display("FAIL rmid_fresh_frame: done=%0d latency=%0d, required 1 2", ok, start_cyc[$] - rden_cyc[$]);
    else n_pass++;
  endtask

  task automatic test_c1;
    logic e1[$];
    logic e;
    logic [1:0] exp_pair;
    e1.push_back(1'b0);
    e1.push_back(1'b1); e1.push_back(1'b0); e1.push_back(1'b1); e1.push_back(1'b0);
`ifdef FIFO_UART_PARITY_EN
    e1.push_back(1'b0);
`endif
    e1.push_back(1'b1);
    @(negedge clk);
    rd_val1 = 1'b1;
    rd_data1 = 4'd5;
    #2;
    n_chk++;
    if (rd_en1 !== 1'b1) $display("FAIL c1_rd_en: rd_en=%b, required 1", rd_en1);
    else n_pass++;
    @(negedge clk);
    rd_val1 = 1'b0;
    #2;
    n_chk++;
    if (tx1 !== 1'b1 || busy1 !== 1'b1 || rd_en1 !== 1'b0)
      $display("FAIL c1_wait: tx=%b busy=%b rd_en=%b, required 1 1 0", tx1, busy1, rd_en1);
    else n_pass++;
    while (e1.size() != 0) begin
      @(negedge clk);
      e = e1.pop_front();
      exp_pair = {e, (e1.size() == 0) ? 1'b1 : 1'b0};
      n_chk++;
      if ({tx1, tx_done1} !== exp_pair)
        $display("FAIL c1_bit: tx,tx_done=%b, required %b (%0d bits left)", {tx1, tx_done1}, exp_pair, e1.size());
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || tx_done1 !== 1'b0)
      $display("FAIL c1_end: tx=%b busy=%b tx_done=%b, required 1 0 0", tx1, busy1, tx_done1);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_idle;
    test_single;
    test_patterns;
    test_back_to_back;
    test_reset_mid;
    test_c1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
